// File: rtl/newtag_enc.sv
// newtag_enc: sequential encoder for the newtag_d tag detector.
// Returns, per requested class, the next 8-bit vector (ascending, wrapping)
// whose detector output equals that class. Each class has its own pointer.
module newtag_enc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_class,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_vec,
  output logic             out_class,
  output logic             wrapped,
  output logic [CNT_W-1:0] emit_cnt0,
  output logic [CNT_W-1:0] emit_cnt1
);

  localparam int unsigned VEC_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] ptr0;
  logic [VEC_W-1:0] ptr1;
  logic [VEC_W-1:0] cand;
  logic             cls;
  logic             z_c;
  logic             hit_c;

  // Bit-exact model of the newtag_d detector output z0.
  function automatic logic detect(input logic [VEC_W-1:0] c);
    logic n19;
    n19 = c[3] & ~(c[4] & c[5]) & ~((c[4] | c[5]) & c[6] & c[7]);
    return ~(c[1] & ~c[0] & ~c[2] & ~n19);
  endfunction

  // Detector evaluation of the current candidate against the requested class.
  assign z_c   = detect(cand);
  assign hit_c = (z_c == cls);

  // Request/search/handoff controller with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr0      <= '0;
      ptr1      <= '0;
      cand      <= '0;
      cls       <= 1'b0;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_class <= 1'b0;
      wrapped   <= 1'b0;
      emit_cnt0 <= '0;
      emit_cnt1 <= '0;
    end else begin
      wrapped <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cand      <= req_class ? ptr1 : ptr0;
            cls       <= req_class;
            req_ready <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit_c) begin
            out_vec   <= cand;
            out_class <= cls;
            out_valid <= 1'b1;
            if (cls) begin
              ptr1 <= cand + VEC_W'(1);
            end else begin
              ptr0 <= cand + VEC_W'(1);
            end
            // Only a pointer rolling over from 0xFF counts as a wrap.
            wrapped <= (cand == {VEC_W{1'b1}});
            state   <= HOLD;
          end else begin
            cand <= cand + VEC_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            if (cls) begin
              if (emit_cnt1 != {CNT_W{1'b1}}) emit_cnt1 <= emit_cnt1 + CNT_W'(1);
            end else begin
              if (emit_cnt0 != {CNT_W{1'b1}}) emit_cnt0 <= emit_cnt0 + CNT_W'(1);
            end
            state <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
